axil_wr_crossbar: RTL and testbench
===================================

Name: axil_wr_crossbar

Overview:
- Write-path (AW/W/B) switch of the AXI4-Lite interconnect. Sits between the master-side ports and the slave-side ports, downstream of the per-slave write arbiters and the address decoders.
- Routing is decided externally: grant_wr[s] names the master granted to slave s, and grant_wr_trans[m] names the slave that master m targets.
- A master/slave pair is connected only when both grants point at each other.
- Small per-slave state tracks AW/W/B phase completion so that each transaction is forwarded exactly once.

Parameters:
- NUMBER_MASTER, 2, number of master ports (>=2).
- NUMBER_SLAVE, 4, number of slave ports (>=2).
- AXI_DATA_WIDTH, 32, data width in bits (multiple of 8).
- AXI_ADDR_WIDTH, 32, address width in bits.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous reset, active-high.
- grant_wr  in  [clog2(NUMBER_MASTER)] x NUMBER_SLAVE  master index granted to each slave.
- grant_wr_trans  in  [clog2(NUMBER_SLAVE)] x NUMBER_MASTER  slave index targeted by each master.
- m_axil_awaddr  in  AXI_ADDR_WIDTH x NUMBER_MASTER; m_axil_awvalid in NUMBER_MASTER; m_axil_awready out NUMBER_MASTER.
- m_axil_wdata  in  AXI_DATA_WIDTH x NUMBER_MASTER; m_axil_wstrb in AXI_DATA_WIDTH/8 x NUMBER_MASTER; m_axil_wvalid in NUMBER_MASTER; m_axil_wready out NUMBER_MASTER.
- m_axil_bresp  out  2 x NUMBER_MASTER; m_axil_bvalid out NUMBER_MASTER; m_axil_bready in NUMBER_MASTER.
- s_axil_awaddr  out  AXI_ADDR_WIDTH x NUMBER_SLAVE; s_axil_awvalid out NUMBER_SLAVE; s_axil_awready in NUMBER_SLAVE.
- s_axil_wdata  out  AXI_DATA_WIDTH x NUMBER_SLAVE; s_axil_wstrb out AXI_DATA_WIDTH/8 x NUMBER_SLAVE; s_axil_wvalid out NUMBER_SLAVE; s_axil_wready in NUMBER_SLAVE.
- s_axil_bresp  in  2 x NUMBER_SLAVE; s_axil_bvalid in NUMBER_SLAVE; s_axil_bready out NUMBER_SLAVE.
- Port shapes: multi-bit per-port fields are unpacked arrays; single-bit per-port signals are packed vectors.

Behaviour:
- conn(s,m) = (grant_wr[s]==m) && (grant_wr_trans[m]==s). Out-of-range indices are never connected.
- Payload muxes are combinational and ungated:
  - s_axil_awaddr/wdata/wstrb[s] = master grant_wr[s] fields.
  - m_axil_bresp[m] = s_axil_bresp[grant_wr_trans[m]].
- Per-slave registers aw_done[s] and w_done[s] (aclk, async-cleared by areset).
- AW channel, with m=grant_wr[s]:
  - s_axil_awvalid[s] = conn & m_awvalid[m] & ~aw_done[s].
  - m_axil_awready[m] = conn & s_awready[s] & ~aw_done[s].
  - An AW handshake sets aw_done[s].
- W channel: same structure with wvalid/wready and w_done[s]. AW and W complete independently, in any order or in the same cycle.
- B channel: only when aw_done & w_done & conn:
  - s_axil_bready[s] = m_bready[m].
  - m_axil_bvalid[m] = s_bvalid[s].
  - A B handshake clears aw_done[s] and w_done[s] on the same edge. The next AW/W can be forwarded the following cycle.
- B before AW/W completion: suppressed. bvalid is not forwarded and bready is held 0.
- Unconnected ports: all valid/ready outputs driven 0. An unconnected master sees awready/wready/bvalid = 0.
- Connection loss: if conn(s,grant_wr[s]) is false at a clock edge, aw_done[s] and w_done[s] clear. The arbiter holds grants from AW until B handshake; dropping grants mid-transaction aborts tracking with no error reporting.
- Reset: while areset=1, every valid/ready output is 0 and aw_done/w_done are 0. Payload muxes still pass data.
- Latency: zero-cycle combinational pass-through. At most one outstanding write per slave.

Test Plan:
- grant_wr={1,0,0,0}, grant_wr_trans={0,0}; M0: awaddr AA, wdata 55. M1: awaddr BB, wdata CC, strb 1. All valids/readies 1; slave bresp {00,01,10,11}, bvalid all 1.
  -> s_awaddr[0]=BB, s_wdata[0]=CC, s_awvalid[0]=s_wvalid[0]=1 in cycle 0.
  -> M1 awready=wready=1, M0 awready=0.
  -> Cycle 1: m_bvalid[1]=1, m_bresp[1]=00.
  -> Cycle 2: AW re-forwarded.
- Same setup, grant_wr_trans[0]=1, grant_wr[1]=0 -> S1 gets awaddr AA, wdata 55; M0 gets bresp 01 after AW/W. M1 and S0 stay independent and concurrent.
- AW only (wvalid=0) for 3 cycles, then W -> awvalid pulses once; bready=0 until W handshake; bvalid forwarded the cycle after.
- No mutual grant (grant_wr[0]=1, grant_wr_trans[1]=2) -> all s_*valid, s_bready, m_*ready and m_bvalid = 0.
- areset asserted after AW and before W -> outputs 0 immediately. After release, AW is re-forwarded because aw_done was cleared.
- m_bready=0 with s_bvalid=1 -> m_bvalid held 1, state held, no new AW forwarded until bready=1.

Source files
------------

// File: rtl/axil_wr_crossbar_if.sv
// AXI4-Lite write-path bundle for the crossbar.
// Master-side and slave-side AW/W/B channels plus routing grants.
interface axil_wr_crossbar_if #(
  parameter int NUMBER_MASTER  = 2,
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
);
  localparam int MW = (NUMBER_MASTER > 1) ?
                      $clog2(NUMBER_MASTER) : 1;
  localparam int SW = (NUMBER_SLAVE > 1) ?
                      $clog2(NUMBER_SLAVE) : 1;
  localparam int STRBW = AXI_DATA_WIDTH / 8;

  logic [MW-1:0] grant_wr       [NUMBER_SLAVE];
  logic [SW-1:0] grant_wr_trans [NUMBER_MASTER];

  logic [AXI_ADDR_WIDTH-1:0] m_axil_awaddr [NUMBER_MASTER];
  logic [NUMBER_MASTER-1:0]  m_axil_awvalid;
  logic [NUMBER_MASTER-1:0]  m_axil_awready;
  logic [AXI_DATA_WIDTH-1:0] m_axil_wdata  [NUMBER_MASTER];
  logic [STRBW-1:0]          m_axil_wstrb  [NUMBER_MASTER];
  logic [NUMBER_MASTER-1:0]  m_axil_wvalid;
  logic [NUMBER_MASTER-1:0]  m_axil_wready;
  logic [1:0]                m_axil_bresp  [NUMBER_MASTER];
  logic [NUMBER_MASTER-1:0]  m_axil_bvalid;
  logic [NUMBER_MASTER-1:0]  m_axil_bready;

  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr [NUMBER_SLAVE];
  logic [NUMBER_SLAVE-1:0]   s_axil_awvalid;
  logic [NUMBER_SLAVE-1:0]   s_axil_awready;
  logic [AXI_DATA_WIDTH-1:0] s_axil_wdata  [NUMBER_SLAVE];
  logic [STRBW-1:0]          s_axil_wstrb  [NUMBER_SLAVE];
  logic [NUMBER_SLAVE-1:0]   s_axil_wvalid;
  logic [NUMBER_SLAVE-1:0]   s_axil_wready;
  logic [1:0]                s_axil_bresp  [NUMBER_SLAVE];
  logic [NUMBER_SLAVE-1:0]   s_axil_bvalid;
  logic [NUMBER_SLAVE-1:0]   s_axil_bready;

  // Crossbar view
  modport slave (
    input  grant_wr, grant_wr_trans,
    input  m_axil_awaddr, m_axil_awvalid,
    output m_axil_awready,
    input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    output m_axil_wready,
    output m_axil_bresp, m_axil_bvalid,
    input  m_axil_bready,
    output s_axil_awaddr, s_axil_awvalid,
    input  s_axil_awready,
    output s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
    input  s_axil_wready,
    input  s_axil_bresp, s_axil_bvalid,
    output s_axil_bready
  );

  // Environment view (masters, slaves and arbiters)
  modport master (
    output grant_wr, grant_wr_trans,
    output m_axil_awaddr, m_axil_awvalid,
    input  m_axil_awready,
    output m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    input  m_axil_wready,
    input  m_axil_bresp, m_axil_bvalid,
    output m_axil_bready,
    input  s_axil_awaddr, s_axil_awvalid,
    output s_axil_awready,
    input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
    output s_axil_wready,
    output s_axil_bresp, s_axil_bvalid,
    input  s_axil_bready
  );
endinterface

// File: rtl/axil_wr_crossbar.sv
// AXI4-Lite write-path switch (AW/W/B) between masters and slaves.
// Per-slave aw/w done flags make each transaction forward exactly once.
module axil_wr_crossbar #(
  parameter int NUMBER_MASTER  = 2,
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic             aclk,
  input  logic             areset,
  axil_wr_crossbar_if.slave bus
);
  localparam int NM = NUMBER_MASTER;
  localparam int NS = NUMBER_SLAVE;
  localparam int MW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  logic [NS-1:0][NM-1:0] w_conn;
  logic [NS-1:0] w_conn_any;
  logic [NS-1:0] r_aw_done, r_w_done;
  logic [NS-1:0] w_aw_done_nxt, w_w_done_nxt;
  logic [NS-1:0] w_s_awvalid, w_s_wvalid, w_s_bready;
  logic [NM-1:0] w_m_awready, w_m_wready, w_m_bvalid;

  // Mutual-grant connection matrix; out-of-range indices never match
  always_comb begin
    w_conn     = '0;
    w_conn_any = '0;
    for (int s = 0; s < NS; s++) begin
      for (int m = 0; m < NM; m++) begin
        if (bus.grant_wr[s] == MW'(m) &&
            bus.grant_wr_trans[m] == SW'(s)) begin
          w_conn[s][m]  = 1'b1;
          w_conn_any[s] = 1'b1;
        end
      end
    end
  end

  // Ungated payload muxes toward slaves
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      bus.s_axil_awaddr[s] = '0;
      bus.s_axil_wdata[s]  = '0;
      bus.s_axil_wstrb[s]  = '0;
      for (int m = 0; m < NM; m++) begin
        if (bus.grant_wr[s] == MW'(m)) begin
          bus.s_axil_awaddr[s] = bus.m_axil_awaddr[m];
          bus.s_axil_wdata[s]  = bus.m_axil_wdata[m];
          bus.s_axil_wstrb[s]  = bus.m_axil_wstrb[m];
        end
      end
    end
  end

  // Ungated response mux toward masters
  always_comb begin
    for (int m = 0; m < NM; m++) begin
      bus.m_axil_bresp[m] = 2'b00;
      for (int s = 0; s < NS; s++) begin
        if (bus.grant_wr_trans[m] == SW'(s)) begin
          bus.m_axil_bresp[m] = bus.s_axil_bresp[s];
        end
      end
    end
  end

  // Handshake routing, gated by connection, phase state and reset
  always_comb begin
    w_s_awvalid = '0;
    w_s_wvalid  = '0;
    w_s_bready  = '0;
    w_m_awready = '0;
    w_m_wready  = '0;
    w_m_bvalid  = '0;
    for (int s = 0; s < NS; s++) begin
      for (int m = 0; m < NM; m++) begin
        if (w_conn[s][m] && !areset) begin
          w_s_awvalid[s] = bus.m_axil_awvalid[m] & ~r_aw_done[s];
          w_m_awready[m] = bus.s_axil_awready[s] & ~r_aw_done[s];
          w_s_wvalid[s]  = bus.m_axil_wvalid[m] & ~r_w_done[s];
          w_m_wready[m]  = bus.s_axil_wready[s] & ~r_w_done[s];
          if (r_aw_done[s] && r_w_done[s]) begin
            w_s_bready[s] = bus.m_axil_bready[m];
            w_m_bvalid[m] = bus.s_axil_bvalid[s];
          end
        end
      end
    end
  end

  assign bus.s_axil_awvalid = w_s_awvalid;
  assign bus.s_axil_wvalid  = w_s_wvalid;
  assign bus.s_axil_bready  = w_s_bready;
  assign bus.m_axil_awready = w_m_awready;
  assign bus.m_axil_wready  = w_m_wready;
  assign bus.m_axil_bvalid  = w_m_bvalid;

  // Phase tracking: set on AW/W handshake, clear on B or lost link
  always_comb begin
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    for (int s = 0; s < NS; s++) begin
      if (!w_conn_any[s]) begin
        w_aw_done_nxt[s] = 1'b0;
        w_w_done_nxt[s]  = 1'b0;
      end else if (w_s_bready[s] && bus.s_axil_bvalid[s]) begin
        w_aw_done_nxt[s] = 1'b0;
        w_w_done_nxt[s]  = 1'b0;
      end else begin
        if (w_s_awvalid[s] && bus.s_axil_awready[s])
          w_aw_done_nxt[s] = 1'b1;
        if (w_s_wvalid[s] && bus.s_axil_wready[s])
          w_w_done_nxt[s] = 1'b1;
      end
    end
  end

  // Phase state registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_aw_done <= '0;
      r_w_done  <= '0;
    end else begin
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end
endmodule

// File: tb/tb_axil_wr_crossbar.sv
// Randomized bench for axil_wr_crossbar.
// Master-centric transaction model predicts every output each cycle.
module tb_axil_wr_crossbar;
  localparam int NM = 2;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = 1;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic areset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  // Per-slave transaction progress seen by the model
  bit addr_taken [NS];
  bit data_taken [NS];

  axil_wr_crossbar_if #(
    .NUMBER_MASTER(NM), .NUMBER_SLAVE(NS),
    .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)
  ) bus ();

  axil_wr_crossbar #(
    .NUMBER_MASTER(NM), .NUMBER_SLAVE(NS),
    .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)
  ) dut (
    .aclk(clk),
    .areset(areset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Check outputs of current cycle, then advance model over one edge
  task automatic step();
    int lnk [NM];
    logic [NS-1:0] e_awv, e_wv, e_br;
    logic [NM-1:0] e_awr, e_wr, e_bv;
    bit nx_a [NS];
    bit nx_d [NS];
    #1;
    if (areset) begin
      foreach (addr_taken[i]) addr_taken[i] = 0;
      foreach (data_taken[i]) data_taken[i] = 0;
    end
    e_awv = '0; e_wv = '0; e_br = '0;
    e_awr = '0; e_wr = '0; e_bv = '0;
    for (int m = 0; m < NM; m++) begin
      int t;
      t = int'(bus.grant_wr_trans[m]);
      lnk[m] = -1;
      if (t < NS && int'(bus.grant_wr[t]) == m) lnk[m] = t;
    end
    for (int m = 0; m < NM; m++) begin
      int t;
      t = lnk[m];
      if (t >= 0 && !areset) begin
        e_awv[t] = bus.m_axil_awvalid[m] && !addr_taken[t];
        e_awr[m] = bus.s_axil_awready[t] && !addr_taken[t];
        e_wv[t]  = bus.m_axil_wvalid[m] && !data_taken[t];
        e_wr[m]  = bus.s_axil_wready[t] && !data_taken[t];
        if (addr_taken[t] && data_taken[t]) begin
          e_br[t] = bus.m_axil_bready[m];
          e_bv[m] = bus.s_axil_bvalid[t];
        end
      end
    end
    chk("s_awvalid", 64'(bus.s_axil_awvalid), 64'(e_awv));
    chk("s_wvalid",  64'(bus.s_axil_wvalid),  64'(e_wv));
    chk("s_bready",  64'(bus.s_axil_bready),  64'(e_br));
    chk("m_awready", 64'(bus.m_axil_awready), 64'(e_awr));
    chk("m_wready",  64'(bus.m_axil_wready),  64'(e_wr));
    chk("m_bvalid",  64'(bus.m_axil_bvalid),  64'(e_bv));
    for (int s = 0; s < NS; s++) begin
      int g;
      g = int'(bus.grant_wr[s]);
      if (g < NM) begin
        chk($sformatf("s_awaddr[%0d]", s),
            64'(bus.s_axil_awaddr[s]), 64'(bus.m_axil_awaddr[g]));
        chk($sformatf("s_wdata[%0d]", s),
            64'(bus.s_axil_wdata[s]), 64'(bus.m_axil_wdata[g]));
        chk($sformatf("s_wstrb[%0d]", s),
            64'(bus.s_axil_wstrb[s]), 64'(bus.m_axil_wstrb[g]));
      end
    end
    for (int m = 0; m < NM; m++) begin
      int t;
      t = int'(bus.grant_wr_trans[m]);
      if (t < NS)
        chk($sformatf("m_bresp[%0d]", m),
            64'(bus.m_axil_bresp[m]), 64'(bus.s_axil_bresp[t]));
    end
    for (int s = 0; s < NS; s++) begin
      nx_a[s] = 0;
      nx_d[s] = 0;
    end
    for (int m = 0; m < NM; m++) begin
      int t;
      t = lnk[m];
      if (t >= 0 && !(e_br[t] && bus.s_axil_bvalid[t])) begin
        nx_a[t] = addr_taken[t] ||
                  (e_awv[t] && bus.s_axil_awready[t]);
        nx_d[t] = data_taken[t] ||
                  (e_wv[t] && bus.s_axil_wready[t]);
      end
    end
    @(posedge clk);
    for (int s = 0; s < NS; s++) begin
      addr_taken[s] = areset ? 1'b0 : nx_a[s];
      data_taken[s] = areset ? 1'b0 : nx_d[s];
    end
    @(negedge clk);
  endtask

  task automatic set_base();
    bus.grant_wr[0] = 1'b1;
    for (int s = 1; s < NS; s++) bus.grant_wr[s] = 1'b0;
    bus.grant_wr_trans[0] = 2'd0;
    bus.grant_wr_trans[1] = 2'd0;
    bus.m_axil_awaddr[0] = 32'hAA;
    bus.m_axil_wdata[0]  = 32'h55;
    bus.m_axil_wstrb[0]  = 4'hF;
    bus.m_axil_awaddr[1] = 32'hBB;
    bus.m_axil_wdata[1]  = 32'hCC;
    bus.m_axil_wstrb[1]  = 4'h1;
    bus.m_axil_awvalid = '1;
    bus.m_axil_wvalid  = '1;
    bus.m_axil_bready  = '1;
    bus.s_axil_awready = '1;
    bus.s_axil_wready  = '1;
    bus.s_axil_bvalid  = '1;
    for (int s = 0; s < NS; s++) bus.s_axil_bresp[s] = 2'(s);
  endtask

  task automatic rand_inputs(bit regrant);
    if (regrant) begin
      for (int m = 0; m < NM; m++)
        bus.grant_wr_trans[m] = SW'($urandom_range(0, NS - 1));
      for (int s = 0; s < NS; s++)
        bus.grant_wr[s] = MW'($urandom_range(0, NM - 1));
      if ($urandom_range(0, 1) == 1) begin
        int m;
        m = int'($urandom_range(0, NM - 1));
        bus.grant_wr[bus.grant_wr_trans[m]] = MW'(m);
      end
    end
    for (int m = 0; m < NM; m++) begin
      bus.m_axil_awaddr[m] = $urandom;
      bus.m_axil_wdata[m]  = $urandom;
      bus.m_axil_wstrb[m]  = 4'($urandom);
    end
    for (int s = 0; s < NS; s++)
      bus.s_axil_bresp[s] = 2'($urandom);
    bus.m_axil_awvalid = NM'($urandom);
    bus.m_axil_wvalid  = NM'($urandom);
    bus.m_axil_bready  = NM'($urandom);
    bus.s_axil_awready = NS'($urandom);
    bus.s_axil_wready  = NS'($urandom);
    bus.s_axil_bvalid  = NS'($urandom);
  endtask

  initial begin
    set_base();
    @(negedge clk);
    step();
    step();
    areset = 1'b0;
    // Mutual grant M1<->S0: AW/W, then B, then re-forward
    repeat (4) step();
    // Add M0<->S1 concurrently
    bus.grant_wr_trans[0] = 2'd1;
    bus.grant_wr[1] = 1'b0;
    repeat (4) step();
    // AW alone for 3 cycles, then W
    bus.m_axil_wvalid = '0;
    repeat (3) step();
    bus.m_axil_wvalid = '1;
    repeat (3) step();
    // No mutual grant anywhere
    set_base();
    bus.grant_wr_trans[1] = 2'd2;
    repeat (3) step();
    // Reset between AW and W
    set_base();
    bus.m_axil_wvalid = '0;
    step();
    areset = 1'b1;
    step();
    areset = 1'b0;
    bus.m_axil_wvalid = '1;
    repeat (3) step();
    // Master stalls B response
    bus.m_axil_bready = '0;
    repeat (4) step();
    bus.m_axil_bready = '1;
    repeat (3) step();
    // Randomized traffic with occasional regrants and resets
    for (int i = 0; i < 600; i++) begin
      rand_inputs($urandom_range(0, 7) == 0);
      areset = ($urandom_range(0, 63) == 0);
      step();
    end
    areset = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
